// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register-file geometry and writeback arbiter state encoding
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback ports, issue tracking and register-file write bus
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic                  a_we;
  logic [REG_ADDR_W-1:0] a_addr;
  logic [REG_DATA_W-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [REG_ADDR_W-1:0] b_addr;
  logic [REG_DATA_W-1:0] b_data;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_addr;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [REG_DATA_W-1:0] write_data;
  logic                  stall_pipe;
  logic [NUM_REGS-1:0]   busy_vec;
  logic                  protocol_err;

  modport master (
    output a_we, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output issue_valid, issue_addr,
    input  b_ready, RegWrite, write_addr, write_data,
    input  stall_pipe, busy_vec, protocol_err
  );

  modport slave (
    input  a_we, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  issue_valid, issue_addr,
    output b_ready, RegWrite, write_addr, write_data,
    output stall_pipe, busy_vec, protocol_err
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-destination bits for in-flight multi-cycle results
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_set_valid,
  input  logic [REG_ADDR_W-1:0] i_set_addr,
  input  logic                  i_clr_valid,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  output logic [NUM_REGS-1:0]   o_busy_vec,
  output logic                  o_err_set,
  output logic                  o_err_clr
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_set_hit;
  logic                w_clr_hit;

  always_comb begin
    w_set_hit  = i_set_valid && (i_set_addr != REG_ZERO);
    w_clr_hit  = i_clr_valid && (i_clr_addr != REG_ZERO);
    w_busy_nxt = r_busy;
    // Set is applied last: a fresh issue supersedes the retiring result.
    if (w_clr_hit) w_busy_nxt[i_clr_addr] = 1'b0;
    if (w_set_hit) w_busy_nxt[i_set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    o_err_set = w_set_hit && r_busy[i_set_addr]
                && !(w_clr_hit && (i_clr_addr == i_set_addr));
    o_err_clr = w_clr_hit && !r_busy[i_clr_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write port arbiter between pipeline and mul/div writeback
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
)
(
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(STARVE_LIMIT - 1);

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_b_pend;
  logic                  r_err;
  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_b_blocked;
  logic [REG_ADDR_W-1:0] w_wr_addr;
  logic [REG_DATA_W-1:0] w_wr_data;
  logic [NUM_REGS-1:0]   w_busy;
  logic                  w_err_set;
  logic                  w_err_clr;
  logic                  w_err_any;

  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (r_state == ST_FORCE) begin
      w_grant_b = bus.b_valid;
    end else if (bus.a_we) begin
      w_grant_a = 1'b1;
    end else begin
      w_grant_b = bus.b_valid;
    end
  end

  assign w_b_blocked = bus.b_valid && !w_grant_b;

  always_comb begin
    w_wr_addr = REG_ZERO;
    w_wr_data = '0;
    if (w_grant_a) begin
      w_wr_addr = bus.a_addr;
      w_wr_data = bus.a_data;
    end else if (w_grant_b) begin
      w_wr_addr = bus.b_addr;
      w_wr_data = bus.b_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_NORMAL: begin
        if (w_b_blocked) begin
          if (r_cnt == CNT_TRIP) w_state_nxt = ST_FORCE;
          if (r_cnt != CNT_MAX)  w_cnt_nxt   = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ST_FORCE: begin
        // B is either accepted now or has illegally dropped; both end the stall.
        w_state_nxt = ST_NORMAL;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_NORMAL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  regfile_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (reset),
    .i_set_valid (bus.issue_valid),
    .i_set_addr  (bus.issue_addr),
    .i_clr_valid (w_grant_b),
    .i_clr_addr  (bus.b_addr),
    .o_busy_vec  (w_busy),
    .o_err_set   (w_err_set),
    .o_err_clr   (w_err_clr)
  );

  // A drop in FORCE is always caught by r_b_pend, since FORCE is only entered from a blocked cycle.
  assign w_err_any = (bus.a_we && (r_state == ST_FORCE))
                   || (r_b_pend && !bus.b_valid)
                   || w_err_set
                   || w_err_clr
                   || (bus.a_we && w_busy[bus.a_addr]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_NORMAL;
      r_cnt    <= '0;
      r_b_pend <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_b_pend <= w_b_blocked;
      r_err    <= r_err | w_err_any;
    end
  end

  assign bus.b_ready      = w_grant_b;
  assign bus.RegWrite     = (w_grant_a || w_grant_b) && (w_wr_addr != REG_ZERO);
  assign bus.write_addr   = w_wr_addr;
  assign bus.write_data   = w_wr_data;
  assign bus.stall_pipe   = (r_state == ST_FORCE);
  assign bus.busy_vec     = w_busy;
  assign bus.protocol_err = r_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and randomized checks against a behavioural arbiter model
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic reset;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          m_force;
  int          m_cnt;
  logic [31:0] m_busy;
  bit          m_err;
  bit          m_pend;
  bit          m_last_gb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_force = 0; m_cnt = 0; m_busy = '0; m_err = 0; m_pend = 0; m_last_gb = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    bit ga, gb;
    logic [4:0]  ea;
    logic [31:0] ed;
    @(negedge clk);
    ga = !m_force && bus.a_we;
    gb = bus.b_valid && (m_force || !bus.a_we);
    ea = ga ? bus.a_addr : (gb ? bus.b_addr : 5'd0);
    ed = ga ? bus.a_data : (gb ? bus.b_data : 32'd0);
    chk("b_ready", {31'd0, bus.b_ready}, {31'd0, gb});
    chk("RegWrite", {31'd0, bus.RegWrite}, {31'd0, (ga || gb) && (ea != 5'd0)});
    chk("write_addr", {27'd0, bus.write_addr}, {27'd0, ea});
    chk("write_data", bus.write_data, ed);
    chk("stall_pipe", {31'd0, bus.stall_pipe}, {31'd0, m_force});
    chk("busy_vec", bus.busy_vec, m_busy);
    chk("protocol_err", {31'd0, bus.protocol_err}, {31'd0, m_err});
    if (bus.a_we && m_force) m_err = 1;
    if (m_pend && !bus.b_valid) m_err = 1;
    if (bus.a_we && m_busy[bus.a_addr]) m_err = 1;
    if (gb && bus.b_addr != 5'd0 && !m_busy[bus.b_addr]) m_err = 1;
    if (bus.issue_valid && bus.issue_addr != 5'd0 && m_busy[bus.issue_addr]
        && !(gb && bus.b_addr == bus.issue_addr)) m_err = 1;
    if (gb) m_busy[bus.b_addr] = 1'b0;
    if (bus.issue_valid) m_busy[bus.issue_addr] = 1'b1;
    m_busy[0] = 1'b0;
    if (m_force) begin
      m_force = 0;
      m_cnt   = 0;
    end else if (bus.b_valid && !gb) begin
      if (m_cnt == LIMIT - 1) m_force = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else begin
      m_cnt = 0;
    end
    m_pend    = bus.b_valid && !gb;
    m_last_gb = gb;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_stall", {31'd0, bus.stall_pipe}, 32'd0);
    chk("rst_busy", bus.busy_vec, 32'd0);
    chk("rst_err", {31'd0, bus.protocol_err}, 32'd0);
    bus.a_we = 0; bus.b_valid = 0; bus.issue_valid = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle();
    bus.a_we = 0; bus.b_valid = 0; bus.issue_valid = 0;
  endtask

  initial begin
    int  s;
    bit  found;
    logic [31:0] saved;
    reset = 1'b0;
    bus.a_we = 0; bus.a_addr = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
    bus.issue_valid = 0; bus.issue_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, bus.stall_pipe}, 32'd0);
    chk("reset_busy", bus.busy_vec, 32'd0);
    chk("reset_err", {31'd0, bus.protocol_err}, 32'd0);
    reset = 1'b1;

    // pipeline write passes straight through
    bus.a_we = 1; bus.a_addr = 5'd5; bus.a_data = 32'h1234;
    sample();
    chk("t1_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    chk("t1_addr", {27'd0, bus.write_addr}, 32'd5);
    chk("t1_data", bus.write_data, 32'h1234);
    chk("t1_b_ready", {31'd0, bus.b_ready}, 32'd0);
    tick();

    // issue then retire r9
    idle(); bus.issue_valid = 1; bus.issue_addr = 5'd9;
    sample(); tick();
    idle();
    sample();
    chk("t2_busy9_set", {31'd0, bus.busy_vec[9]}, 32'd1);
    tick();
    bus.b_valid = 1; bus.b_addr = 5'd9; bus.b_data = 32'hDEADBEEF;
    sample();
    chk("t2_b_ready", {31'd0, bus.b_ready}, 32'd1);
    chk("t2_addr", {27'd0, bus.write_addr}, 32'd9);
    chk("t2_data", bus.write_data, 32'hDEADBEEF);
    tick();
    idle();
    sample();
    chk("t2_busy9_clr", {31'd0, bus.busy_vec[9]}, 32'd0);
    tick();

    // starvation forces a one-request stall
    bus.issue_valid = 1; bus.issue_addr = 5'd12;
    sample(); tick();
    idle();
    bus.b_valid = 1; bus.b_addr = 5'd12; bus.b_data = $urandom;
    bus.a_we = 1; bus.a_addr = 5'd3;
    for (int i = 0; i < LIMIT; i++) begin
      bus.a_data = $urandom;
      sample();
      chk("t3_no_stall", {31'd0, bus.stall_pipe}, 32'd0);
      chk("t3_blocked", {31'd0, bus.b_ready}, 32'd0);
      tick();
    end
    bus.a_we = 0;
    sample();
    chk("t3_stall", {31'd0, bus.stall_pipe}, 32'd1);
    chk("t3_b_ready", {31'd0, bus.b_ready}, 32'd1);
    tick();
    idle();
    sample();
    chk("t3_unstall", {31'd0, bus.stall_pipe}, 32'd0);
    chk("t3_err", {31'd0, bus.protocol_err}, 32'd0);
    tick();

    // re-issue on the retiring edge keeps the bit set
    bus.issue_valid = 1; bus.issue_addr = 5'd7;
    sample(); tick();
    bus.b_valid = 1; bus.b_addr = 5'd7; bus.b_data = 32'h77;
    sample(); tick();
    idle();
    sample();
    chk("t4_busy7", {31'd0, bus.busy_vec[7]}, 32'd1);
    tick();
    bus.b_valid = 1; bus.b_addr = 5'd7;
    sample(); tick();

    // handshake to r0 writes nothing
    idle();
    bus.b_valid = 1; bus.b_addr = 5'd0; bus.b_data = 32'hFFFFFFFF;
    saved = m_busy;
    sample();
    chk("t5_b_ready", {31'd0, bus.b_ready}, 32'd1);
    chk("t5_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    tick();
    idle();
    sample();
    chk("t5_busy", bus.busy_vec, saved);
    tick();

    // reset while forcing
    bus.issue_valid = 1; bus.issue_addr = 5'd14;
    sample(); tick();
    idle();
    bus.b_valid = 1; bus.b_addr = 5'd14; bus.a_we = 1; bus.a_addr = 5'd2;
    for (int i = 0; i < LIMIT; i++) begin
      sample(); tick();
    end
    bus.a_we = 0;
    chk("t6_in_force", {31'd0, bus.stall_pipe}, 32'd1);
    #2;
    do_reset();

    // a_we during the stall latches the error
    bus.issue_valid = 1; bus.issue_addr = 5'd15;
    sample(); tick();
    idle();
    bus.b_valid = 1; bus.b_addr = 5'd15; bus.a_we = 1; bus.a_addr = 5'd4;
    for (int i = 0; i < LIMIT; i++) begin
      sample(); tick();
    end
    sample(); tick();
    idle();
    sample();
    chk("t7_err", {31'd0, bus.protocol_err}, 32'd1);
    tick();
    sample();
    chk("t7_err_sticky", {31'd0, bus.protocol_err}, 32'd1);
    tick();
    do_reset();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      if (c % 100 == 99) do_reset();
      bus.a_we   = m_force ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      bus.a_addr = 5'($urandom);
      bus.a_data = $urandom;
      if (bus.b_valid && !m_last_gb) begin
        if ($urandom_range(0, 15) == 0) bus.b_valid = 0;
      end else begin
        bus.b_valid = ($urandom_range(0, 2) == 0);
        bus.b_addr  = 5'($urandom);
        bus.b_data  = $urandom;
        if (m_busy != 0 && $urandom_range(0, 3) != 0) begin
          s = $urandom_range(0, 31);
          found = 0;
          for (int k = 0; k < 32; k++) begin
            if (!found && m_busy[(s + k) % 32]) begin
              bus.b_addr = 5'((s + k) % 32);
              found = 1;
            end
          end
        end
      end
      bus.issue_valid = ($urandom_range(0, 3) == 0);
      bus.issue_addr  = 5'($urandom);
      sample();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
